// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - shared limits, state encoding and field mask helper for time_set_ctrl
package time_pkg;

    localparam logic [5:0] HOUR_MAX   = 6'd23;
    localparam logic [5:0] MINUTE_MAX = 6'd59;
    localparam logic [5:0] SECOND_MAX = 6'd59;

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_SET_H  = 3'd1,
        ST_SET_M  = 3'd2,
        ST_SET_S  = 3'd3,
        ST_COMMIT = 3'd4
    } state_t;

    // One-hot {hour,minute,second} of the field being edited in a given state.
    function automatic logic [2:0] field_mask(input state_t st);
        logic [2:0] m;
        m = 3'b000;
        case (st)
            ST_SET_H: m = 3'b100;
            ST_SET_M: m = 3'b010;
            ST_SET_S: m = 3'b001;
            default:  m = 3'b000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// rtl/time_set_ctrl_if.sv - key/time/control bundle between keypad+counter (master) and time_set_ctrl (slave)
// Signals: key_mode_p/key_inc_p/key_dec_p single-cycle pulses, cur_* live time,
//          run_en, load_en, set_*, blink_mask, editing returned by the controller.
interface time_set_ctrl_if;
    logic       key_mode_p;
    logic       key_inc_p;
    logic       key_dec_p;
    logic [5:0] cur_hour;
    logic [5:0] cur_minute;
    logic [5:0] cur_second;
    logic       run_en;
    logic       load_en;
    logic [5:0] set_hour;
    logic [5:0] set_minute;
    logic [5:0] set_second;
    logic [2:0] blink_mask;
    logic       editing;

    modport master (
        output key_mode_p, key_inc_p, key_dec_p, cur_hour, cur_minute, cur_second,
        input  run_en, load_en, set_hour, set_minute, set_second, blink_mask, editing
    );

    modport slave (
        input  key_mode_p, key_inc_p, key_dec_p, cur_hour, cur_minute, cur_second,
        output run_en, load_en, set_hour, set_minute, set_second, blink_mask, editing
    );
endinterface

// File: rtl/time_field_adj.sv
// rtl/time_field_adj.sv - one 6-bit shadow time field with snapshot, wrap inc/dec and clear
// Ports: sclk, nrst (async active-low); snap/snap_val load the live value;
//        clr forces zero; inc/dec step with wrap at MAX; val is the shadow value.
module time_field_adj #(
    parameter logic [5:0] MAX = 6'd59
) (
    input  logic       sclk,
    input  logic       nrst,
    input  logic       snap,
    input  logic [5:0] snap_val,
    input  logic       clr,
    input  logic       inc,
    input  logic       dec,
    output logic [5:0] val
);
    logic [5:0] val_q, val_d;

    always_comb begin
        val_d = val_q;
        if (snap) begin
            val_d = snap_val;
        end else if (clr) begin
            val_d = 6'd0;
        end else if (inc && !dec) begin
            // >= so an out-of-range snapshot still wraps back into range
            val_d = (val_q >= MAX) ? 6'd0 : val_q + 6'd1;
        end else if (dec && !inc) begin
            val_d = (val_q == 6'd0) ? MAX : val_q - 6'd1;
        end
    end

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) val_q <= 6'd0;
        else       val_q <= val_d;
    end

    assign val = val_q;
endmodule

// File: rtl/time_set_ctrl.sv
// rtl/time_set_ctrl.sv - time-setting sequencer: pauses the RTC, edits shadow H/M/S, loads on commit
// Ports: sclk, nrst (async active-low), tif (slave side of time_set_ctrl_if).
// Optional: define SECOND_ZERO_EN to skip the seconds field and load seconds=0.
module time_set_ctrl
    import time_pkg::*;
#(
    parameter logic [28:0] TIMEOUT_MAX = 29'd499_999_999,
    parameter logic [24:0] BLINK_HALF  = 25'd12_499_999
) (
    input  logic             sclk,
    input  logic             nrst,
    time_set_ctrl_if.slave   tif
);
    state_t      state_q, state_d;
    logic [28:0] tmo_q, tmo_d;
    logic [24:0] blk_cnt_q, blk_cnt_d;
    logic        blk_ph_q, blk_ph_d;
    logic        run_en_q, run_en_d;
    logic        load_en_q, load_en_d;
    logic        editing_q, editing_d;
    logic [2:0]  blink_mask_q, blink_mask_d;

    logic in_set, next_set, any_key, adj_press, inc_g, dec_g, snap, sec_clr;

    always_comb begin
        state_d   = state_q;
        tmo_d     = tmo_q;
        blk_cnt_d = blk_cnt_q;
        blk_ph_d  = blk_ph_q;

        in_set    = (state_q == ST_SET_H) || (state_q == ST_SET_M) || (state_q == ST_SET_S);
        any_key   = tif.key_mode_p || tif.key_inc_p || tif.key_dec_p;
        // mode wins: an inc/dec arriving with mode is dropped
        inc_g     = in_set && !tif.key_mode_p && tif.key_inc_p;
        dec_g     = in_set && !tif.key_mode_p && tif.key_dec_p;
        adj_press = inc_g || dec_g;
        snap      = (state_q == ST_RUN) && tif.key_mode_p;

        case (state_q)
            ST_RUN:    if (tif.key_mode_p) state_d = ST_SET_H;
            ST_SET_H:  if (tif.key_mode_p) state_d = ST_SET_M;
`ifdef SECOND_ZERO_EN
            ST_SET_M:  if (tif.key_mode_p) state_d = ST_COMMIT;
`else
            ST_SET_M:  if (tif.key_mode_p) state_d = ST_SET_S;
`endif
            ST_SET_S:  if (tif.key_mode_p) state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase

        if (in_set) begin
            if (any_key) begin
                tmo_d = 29'd0;
            end else if (tmo_q == TIMEOUT_MAX) begin
                state_d = ST_RUN;   // abandon edit, no load
                tmo_d   = 29'd0;
            end else begin
                tmo_d = tmo_q + 29'd1;
            end

            if (adj_press) begin
                blk_cnt_d = 25'd0;
                blk_ph_d  = 1'b0;
            end else if (blk_cnt_q == BLINK_HALF) begin
                blk_cnt_d = 25'd0;
                blk_ph_d  = ~blk_ph_q;
            end else begin
                blk_cnt_d = blk_cnt_q + 25'd1;
            end
        end else begin
            tmo_d = 29'd0;
        end

        // blink state is only meaningful while a field is being edited
        next_set = (state_d == ST_SET_H) || (state_d == ST_SET_M) || (state_d == ST_SET_S);
        if (!next_set) begin
            blk_cnt_d = 25'd0;
            blk_ph_d  = 1'b0;
        end

        run_en_d     = (state_d == ST_RUN);
        load_en_d    = (state_d == ST_COMMIT);
        editing_d    = (state_d != ST_RUN);
        blink_mask_d = blk_ph_d ? field_mask(state_d) : 3'b000;
    end

`ifdef SECOND_ZERO_EN
    assign sec_clr = (state_q == ST_SET_M) && tif.key_mode_p;
`else
    assign sec_clr = 1'b0;
`endif

    always_ff @(posedge sclk or negedge nrst) begin
        if (!nrst) begin
            state_q      <= ST_RUN;
            tmo_q        <= 29'd0;
            blk_cnt_q    <= 25'd0;
            blk_ph_q     <= 1'b0;
            run_en_q     <= 1'b1;
            load_en_q    <= 1'b0;
            editing_q    <= 1'b0;
            blink_mask_q <= 3'b000;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            blk_cnt_q    <= blk_cnt_d;
            blk_ph_q     <= blk_ph_d;
            run_en_q     <= run_en_d;
            load_en_q    <= load_en_d;
            editing_q    <= editing_d;
            blink_mask_q <= blink_mask_d;
        end
    end

    time_field_adj #(.MAX(HOUR_MAX)) u_hour (
        .sclk(sclk), .nrst(nrst), .snap(snap), .snap_val(tif.cur_hour), .clr(1'b0),
        .inc(inc_g && (state_q == ST_SET_H)), .dec(dec_g && (state_q == ST_SET_H)),
        .val(tif.set_hour)
    );

    time_field_adj #(.MAX(MINUTE_MAX)) u_minute (
        .sclk(sclk), .nrst(nrst), .snap(snap), .snap_val(tif.cur_minute), .clr(1'b0),
        .inc(inc_g && (state_q == ST_SET_M)), .dec(dec_g && (state_q == ST_SET_M)),
        .val(tif.set_minute)
    );

    time_field_adj #(.MAX(SECOND_MAX)) u_second (
        .sclk(sclk), .nrst(nrst), .snap(snap), .snap_val(tif.cur_second), .clr(sec_clr),
        .inc(inc_g && (state_q == ST_SET_S)), .dec(dec_g && (state_q == ST_SET_S)),
        .val(tif.set_second)
    );

    assign tif.run_en     = run_en_q;
    assign tif.load_en    = load_en_q;
    assign tif.editing    = editing_q;
    assign tif.blink_mask = blink_mask_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb/tb_time_set_ctrl.sv - directed table-driven bench for time_set_ctrl (honours SECOND_ZERO_EN)
module tb_time_set_ctrl;
    logic sclk;
    logic nrst;
    int   n_chk;
    int   n_fail;

    time_set_ctrl_if tif();

    time_set_ctrl #(.TIMEOUT_MAX(29'd20), .BLINK_HALF(25'd3)) dut (
        .sclk(sclk),
        .nrst(nrst),
        .tif (tif)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    typedef struct {
        logic m, i, d;
        int   ch, cm, cs;
        logic ed, run, ld;
        int   sh, sm, ss;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic m, i, d, input int ch, cm, cs,
                       input logic ed, run, ld, input int sh, sm, ss);
        vec_t v;
        v.m = m; v.i = i; v.d = d; v.ch = ch; v.cm = cm; v.cs = cs;
        v.ed = ed; v.run = run; v.ld = ld; v.sh = sh; v.sm = sm; v.ss = ss;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse(input logic m, i, d);
        tif.key_mode_p = m; tif.key_inc_p = i; tif.key_dec_p = d;
        @(posedge sclk); #1;
        tif.key_mode_p = 1'b0; tif.key_inc_p = 1'b0; tif.key_dec_p = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        nrst = 1'b0;
        tif.key_mode_p = 1'b0; tif.key_inc_p = 1'b0; tif.key_dec_p = 1'b0;
        tif.cur_hour = 6'd0; tif.cur_minute = 6'd0; tif.cur_second = 6'd0;

        // Block A: snapshot 12:34:56, adjust, simultaneous keys
        add(0,0,0, 12,34,56, 0,1,0,  0, 0, 0);
        add(0,1,0, 12,34,56, 0,1,0,  0, 0, 0);
        add(1,0,0, 12,34,56, 1,0,0, 12,34,56);
        add(0,1,0, 12,34,56, 1,0,0, 13,34,56);
        add(0,0,1, 12,34,56, 1,0,0, 12,34,56);
        add(0,1,1, 12,34,56, 1,0,0, 12,34,56);
        add(1,1,0, 12,34,56, 1,0,0, 12,34,56);
        add(0,0,1, 12,34,56, 1,0,0, 12,33,56);
`ifndef SECOND_ZERO_EN
        add(1,0,0, 12,34,56, 1,0,0, 12,33,56);
        add(0,1,0, 12,34,56, 1,0,0, 12,33,57);
        add(1,0,0, 12,34,56, 1,0,1, 12,33,57);
        add(0,0,0, 12,34,56, 0,1,0, 12,33,57);
`else
        add(1,0,0, 12,34,56, 1,0,1, 12,33, 0);
        add(0,0,0, 12,34,56, 0,1,0, 12,33, 0);
`endif
        // Block B: wrap limits from 23:00:59
        add(1,0,0, 23, 0,59, 1,0,0, 23, 0,59);
        add(0,1,0, 23, 0,59, 1,0,0,  0, 0,59);
        add(0,0,1, 23, 0,59, 1,0,0, 23, 0,59);
        add(1,0,0, 23, 0,59, 1,0,0, 23, 0,59);
        add(0,0,1, 23, 0,59, 1,0,0, 23,59,59);
        add(0,1,0, 23, 0,59, 1,0,0, 23, 0,59);
`ifndef SECOND_ZERO_EN
        add(1,0,0, 23, 0,59, 1,0,0, 23, 0,59);
        add(0,1,0, 23, 0,59, 1,0,0, 23, 0, 0);
        add(0,0,1, 23, 0,59, 1,0,0, 23, 0,59);
        add(1,0,0, 23, 0,59, 1,0,1, 23, 0,59);
        add(0,0,0, 23, 0,59, 0,1,0, 23, 0,59);
`else
        add(1,0,0, 23, 0,59, 1,0,1, 23, 0, 0);
        add(0,0,0, 23, 0,59, 0,1,0, 23, 0, 0);
`endif
        // Block C: edit to 08:15:30 and commit
        add(1,0,0,  7,15,30, 1,0,0,  7,15,30);
        add(0,1,0,  7,15,30, 1,0,0,  8,15,30);
        add(1,0,0,  7,15,30, 1,0,0,  8,15,30);
`ifndef SECOND_ZERO_EN
        add(1,0,0,  7,15,30, 1,0,0,  8,15,30);
        add(1,0,0,  7,15,30, 1,0,1,  8,15,30);
        add(0,0,0,  7,15,30, 0,1,0,  8,15,30);
`else
        add(1,0,0,  7,15,30, 1,0,1,  8,15, 0);
        add(0,0,0,  7,15,30, 0,1,0,  8,15, 0);
`endif

        #12;
        chk("rst_editing",  32'(tif.editing),    32'(0));
        chk("rst_run_en",   32'(tif.run_en),     32'(1));
        chk("rst_load_en",  32'(tif.load_en),    32'(0));
        chk("rst_blink",    32'(tif.blink_mask), 32'(0));
        chk("rst_set_hour", 32'(tif.set_hour),   32'(0));
        chk("rst_set_sec",  32'(tif.set_second), 32'(0));
        #10 nrst = 1'b1;
        @(posedge sclk); #1;

        foreach (vq[k]) begin
            tif.key_mode_p = vq[k].m; tif.key_inc_p = vq[k].i; tif.key_dec_p = vq[k].d;
            tif.cur_hour   = 6'(vq[k].ch);
            tif.cur_minute = 6'(vq[k].cm);
            tif.cur_second = 6'(vq[k].cs);
            @(posedge sclk); #1;
            chk($sformatf("row%0d_editing", k), 32'(tif.editing),    32'(vq[k].ed));
            chk($sformatf("row%0d_run_en", k),  32'(tif.run_en),     32'(vq[k].run));
            chk($sformatf("row%0d_load_en", k), 32'(tif.load_en),    32'(vq[k].ld));
            chk($sformatf("row%0d_set_hour", k),32'(tif.set_hour),   32'(vq[k].sh));
            chk($sformatf("row%0d_set_min", k), 32'(tif.set_minute), 32'(vq[k].sm));
            chk($sformatf("row%0d_set_sec", k), 32'(tif.set_second), 32'(vq[k].ss));
            tif.key_mode_p = 1'b0; tif.key_inc_p = 1'b0; tif.key_dec_p = 1'b0;
        end

        // Timeout: 20 idle cycles stay in SET_M, the 21st returns to RUN without load
        pulse(1,0,0);
        pulse(1,0,0);
        for (int i = 1; i <= 20; i++) begin
            @(posedge sclk); #1;
            chk($sformatf("tmo_hold%0d_editing", i), 32'(tif.editing), 32'(1));
            chk($sformatf("tmo_hold%0d_load", i),    32'(tif.load_en), 32'(0));
        end
        @(posedge sclk); #1;
        chk("tmo_exit_editing", 32'(tif.editing), 32'(0));
        chk("tmo_exit_run_en",  32'(tif.run_en),  32'(1));
        chk("tmo_exit_load",    32'(tif.load_en), 32'(0));

        // Blink in SET_M: 4 cycles blank-off, 4 cycles minute blanked; inc forces visible
        pulse(1,0,0);
        pulse(1,0,0);
        pulse(0,1,0);
        chk("blink_after_inc", 32'(tif.blink_mask), 32'(0));
        for (int i = 1; i <= 13; i++) begin
            @(posedge sclk); #1;
            chk($sformatf("blink_cyc%0d", i), 32'(tif.blink_mask),
                (((i / 4) % 2) == 1) ? 32'(3'b010) : 32'(0));
        end
        pulse(0,1,0);
        chk("blink_inc_forces_off", 32'(tif.blink_mask), 32'(0));

        // Asynchronous reset mid-edit aborts with no load
        #2 nrst = 1'b0;
        #1;
        chk("abort_editing", 32'(tif.editing),    32'(0));
        chk("abort_run_en",  32'(tif.run_en),     32'(1));
        chk("abort_load",    32'(tif.load_en),    32'(0));
        chk("abort_set_min", 32'(tif.set_minute), 32'(0));
        chk("abort_blink",   32'(tif.blink_mask), 32'(0));
        #10 nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge sclk); #1;
            chk($sformatf("post_abort%0d_load", i),    32'(tif.load_en), 32'(0));
            chk($sformatf("post_abort%0d_editing", i), 32'(tif.editing), 32'(0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
Time-setting sequencer for the real-time hour/minute/second counter.
- Inputs: pre-debounced single-cycle key pulses, plus the counter's live time.
- While the user edits a field, the block pauses the counter, holds editable shadow values and drives blink masks for the segment display.
- On commit it issues a one-cycle parallel load to the counter.

Parameters:
TIMEOUT_MAX, 29'd499_999_999, idle cycles (10 s at 50 MHz) in any set state before abort without load.
BLINK_HALF, 25'd12_499_999, cycles per blink half-period (0.25 s at 50 MHz).
HOUR_MAX, 6'd23, hour wrap limit.
MINUTE_MAX, 6'd59, minute wrap limit.
SECOND_MAX, 6'd59, second wrap limit.

Ports:
sclk  in  1  system clock.
nrst  in  1  asynchronous active-low reset.
key_mode_p  in  1  one-cycle pulse: enter set mode / advance field / commit.
key_inc_p  in  1  one-cycle pulse: increment edited field.
key_dec_p  in  1  one-cycle pulse: decrement edited field.
cur_hour  in  6  live hour from counter.
cur_minute  in  6  live minute from counter.
cur_second  in  6  live second from counter.
run_en  out  1  counter enable; 0 freezes counting.
load_en  out  1  one-cycle load strobe to counter.
set_hour  out  6  shadow hour, also the load value.
set_minute  out  6  shadow minute.
set_second  out  6  shadow second.
blink_mask  out  3  {hour,minute,second}; 1 = blank that field this cycle.
editing  out  1  high in any set state; display shows set_* instead of cur_*.

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=RUN, run_en=1, load_en=0, editing=0, blink_mask=0.
  - set_hour/set_minute/set_second=0; timeout counter=0; blink counter=0; blink phase=0.
- States: RUN, SET_H, SET_M, SET_S, COMMIT. All outputs registered.
- RUN:
  - key_mode_p → snapshot cur_* into set_* that edge; next state SET_H.
  - run_en=0 and editing=1 from the next cycle.
  - inc/dec ignored.
- SET_H / SET_M / SET_S:
  - key_mode_p advances SET_H→SET_M→SET_S→COMMIT.
  - key_inc_p: field+1; hour wraps 23→0, minute/second wrap 59→0.
  - key_dec_p: field−1; hour wraps 0→23, minute/second wrap 0→59.
- Simultaneous keys:
  - mode has priority; inc/dec in the same cycle are dropped.
  - inc and dec together (no mode) → no change.
- COMMIT (exactly 1 cycle):
  - load_en=1 with set_* stable; run_en=0.
  - Next cycle: state RUN, run_en=1, load_en=0, editing=0.
  - Load and restart latency from the final mode pulse = 2 cycles.
- Timeout:
  - Counter clears on entry to any set state and on any key pulse.
  - Increments every cycle in set states.
  - On reaching TIMEOUT_MAX → RUN, no load_en, run_en=1 (counter resumes from its frozen value).
- Blink:
  - Counter runs only in set states; phase toggles every BLINK_HALF+1 cycles.
  - blink_mask = one-hot of the edited field while phase=1, else 0.
  - Any inc/dec forces phase=0 and clears the blink counter, so the digit stays visible while adjusting.
  - In RUN: blink_mask=0, phase=0.
- set_* hold their values in RUN (not tracked) until the next entry.
- Deasserting nrst mid-edit aborts the edit; no load is issued.

Optional Feature:
- Macro: SECOND_ZERO_EN.
- Defined: SET_S is skipped; mode in SET_M goes directly to COMMIT, and set_second is forced to 0 on COMMIT entry, so the load writes seconds=0.
- Undefined: full H→M→S sequence as above.

Decomposition:
- Package time_pkg:
  - HOUR_MAX, MINUTE_MAX, SECOND_MAX.
  - State encoding constants: ST_RUN, ST_SET_H, ST_SET_M, ST_SET_S, ST_COMMIT (3 bits).
- Sub-module time_field_adj:
  - One 6-bit shadow register with parameter MAX.
  - Inputs: snapshot load, inc, dec (with wrap), and SECOND_ZERO_EN clear.
  - Instantiated three times.

Test Plan:
1. Reset, cur=12:34:56, mode pulse → next cycle editing=1, run_en=0, set=12:34:56.
2. In SET_H at 23, inc → 0; dec → 23. In SET_M at 0, dec → 59.
3. Edit to 08:15:30, mode ×3 → load_en high exactly 1 cycle with 08:15:30, then run_en=1 next cycle.
4. Mode and inc in the same cycle while in SET_H → state SET_M, hour unchanged. Inc+dec together → no change.
5. TIMEOUT_MAX=20 override, enter SET_M, no keys for 21 cycles → RUN, load_en never asserted, run_en=1.
6. BLINK_HALF=3 override, in SET_M → blink_mask toggles 000/010 every 4 cycles; inc forces 000. With SECOND_ZERO_EN, mode ×2 → load with second=0.
